// File: rtl/spi_slave_if_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if_if
//  Description : Bus bundle for the SPI slave endpoint. It carries the SPI
//                pins and the transmit/receive word handshake. When the
//                macro SPI_SLAVE_OVERRUN_EN is defined, the bundle also
//                carries rx_ack_i and overrun_o.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_if_if #(
    parameter int DW = 8
);
    logic          sclk_i;
    logic          ss_n_i;
    logic          mosi_i;
    logic          miso_o;
    logic          miso_oe_o;
    logic [DW-1:0] din_i;
    logic          load_i;
    logic          ready_o;
    logic [DW-1:0] dout_o;
    logic          rx_valid_o;
    logic          busy_o;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic          rx_ack_i;
    logic          overrun_o;

    modport slave (
        input  sclk_i, ss_n_i, mosi_i, din_i, load_i, rx_ack_i,
        output miso_o, miso_oe_o, ready_o, dout_o, rx_valid_o, busy_o, overrun_o
    );
    modport master (
        output sclk_i, ss_n_i, mosi_i, din_i, load_i, rx_ack_i,
        input  miso_o, miso_oe_o, ready_o, dout_o, rx_valid_o, busy_o, overrun_o
    );
`else
    modport slave (
        input  sclk_i, ss_n_i, mosi_i, din_i, load_i,
        output miso_o, miso_oe_o, ready_o, dout_o, rx_valid_o, busy_o
    );
    modport master (
        output sclk_i, ss_n_i, mosi_i, din_i, load_i,
        input  miso_o, miso_oe_o, ready_o, dout_o, rx_valid_o, busy_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/spi_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : SPI slave endpoint. The SPI pins are oversampled in the clk_i
//                domain. Receive data is shifted in MSB-first. Transmit words
//                come from a one-entry holding buffer that is filled through a
//                ready/load handshake.
//                Optional feature: SPI_SLAVE_OVERRUN_EN adds the sticky
//                overrun_o flag and the rx_ack_i consumer acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_if #(
    parameter int            DW         = 8,
    parameter bit            CPOL       = 1'b0,
    parameter bit            CPHA       = 1'b0,
    parameter logic [DW-1:0] DEFAULT_TX = {DW{1'b1}}
) (
    input  wire logic         clk_i,
    input  wire logic         reset_i,
    spi_slave_if_if.slave     bus
);
    localparam int            CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          sclk_s1, sclk_s2, sclk_d;
    logic          ss_s1, ss_s2, ss_d;
    logic          mosi_s1, mosi_s2;

    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] rx_shift;
    logic [DW-1:0] tx_shift;
    logic [DW-1:0] tx_buf;
    logic          buf_full;
    logic          skip_shift;   // CPHA=1: MSB already on miso, skip first leading edge
    logic          reload_pend;  // CPHA=0: reload at the trailing edge after the last sample
    logic [DW-1:0] dout;
    logic          rx_valid;

    logic          sclk_chg, lead_edge, trail_edge, sample_edge, shift_edge;
    logic          ss_fall, ss_rise;
    logic          frame_load, do_sample, do_shift, clr_skip, frame_done;
    logic [DW-1:0] rx_word;

    // Two-flop synchronizers plus one history flop on sclk and ss_n for edge detection
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_d  <= CPOL;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= bus.sclk_i;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            ss_s1   <= bus.ss_n_i;
            ss_s2   <= ss_s1;
            ss_d    <= ss_s2;
            mosi_s1 <= bus.mosi_i;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_chg    = sclk_s2 ^ sclk_d;
    assign lead_edge   = sclk_chg & (sclk_s2 != CPOL);
    assign trail_edge  = sclk_chg & (sclk_s2 == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign ss_fall     = ss_d & ~ss_s2;
    assign ss_rise     = ~ss_d & ss_s2;
    assign rx_word     = {rx_shift[DW-2:0], mosi_s2};

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle datapath strobes
    always_comb begin
        state_next = state;
        frame_load = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        clr_skip   = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_next = ST_ACTIVE;
                    frame_load = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_next = ST_IDLE;
                end else begin
                    if (sample_edge) begin
                        do_sample  = 1'b1;
                        frame_done = (bit_cnt == LAST);
                    end
                    if (shift_edge) begin
                        if (!CPHA && reload_pend) begin
                            frame_load = 1'b1;
                        end else if (CPHA && skip_shift) begin
                            clr_skip = 1'b1;
                        end else begin
                            do_shift = 1'b1;
                        end
                    end
                    if (CPHA && frame_done) begin
                        frame_load = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Shift registers, bit counter, received word and transmit holding buffer
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            buf_full    <= 1'b0;
            skip_shift  <= 1'b0;
            reload_pend <= 1'b0;
            dout        <= '0;
            rx_valid    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // A deselected partial frame is discarded by clearing the counter here
            if (state == ST_IDLE) begin
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
            if (do_sample) begin
                rx_shift <= rx_word;
                if (frame_done) begin
                    bit_cnt     <= '0;
                    dout        <= rx_word;
                    rx_valid    <= 1'b1;
                    reload_pend <= ~CPHA;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (frame_load) begin
                tx_shift    <= buf_full ? tx_buf : DEFAULT_TX;
                skip_shift  <= 1'b1;
                reload_pend <= 1'b0;
            end else if (do_shift) begin
                tx_shift <= {tx_shift[DW-2:0], 1'b0};
            end
            if (clr_skip) begin
                skip_shift <= 1'b0;
            end
            if (frame_load && buf_full) begin
                buf_full <= 1'b0;
            end
            // Uses the pre-edge buffer state, so a load colliding with a reload of
            // a full buffer is dropped, while one colliding with an empty reload is kept
            if (bus.load_i && !buf_full) begin
                tx_buf   <= bus.din_i;
                buf_full <= 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic word_pend;
    logic overrun;

    // Unconsumed-word tracking and sticky overrun status
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            word_pend <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_done) begin
                word_pend <= 1'b1;
            end else if (bus.rx_ack_i) begin
                word_pend <= 1'b0;
            end
            if (bus.rx_ack_i && !word_pend) begin
                overrun <= 1'b0;
            end
            if ((frame_done && word_pend && !bus.rx_ack_i) ||
                (frame_load && !buf_full && !ss_s2)) begin
                overrun <= 1'b1;
            end
        end
    end

    assign bus.overrun_o = overrun;
`endif

    assign bus.miso_oe_o  = (state == ST_ACTIVE);
    assign bus.miso_o     = (state == ST_ACTIVE) ? tx_shift[DW-1] : 1'b0;
    assign bus.ready_o    = ~buf_full;
    assign bus.dout_o     = dout;
    assign bus.rx_valid_o = rx_valid;
    assign bus.busy_o     = (state == ST_ACTIVE) && (bit_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_if
//  Description : Directed bench for spi_slave_if. Instance u_dut0 runs in mode 0
//                and instance u_dut3 in mode 3. A bench-level SPI master is
//                steered to one instance at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;
    localparam int HALF = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       ss_n  = 1'b1;
    logic       mosi  = 1'b0;
    logic       mode3 = 1'b0;
    logic       ld0   = 1'b0;
    logic       ld3   = 1'b0;
    logic [7:0] din0  = 8'h00;
    logic [7:0] din3  = 8'h00;
    logic       miso;
    logic [7:0] rx;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       ack = 1'b0;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         rx_cnt0  = 0;
    int         rx_cnt3  = 0;
    logic [7:0] rx_last0 = 8'h00;
    logic [7:0] rx_last3 = 8'h00;
    logic [7:0] rx_prev3 = 8'h00;

    always #5 clk = ~clk;

    spi_slave_if_if #(.DW(8)) bus0 ();
    spi_slave_if_if #(.DW(8)) bus3 ();

    assign bus0.sclk_i = mode3 ? 1'b0 : sclk;
    assign bus0.ss_n_i = mode3 ? 1'b1 : ss_n;
    assign bus0.mosi_i = mosi;
    assign bus0.din_i  = din0;
    assign bus0.load_i = ld0;
    assign bus3.sclk_i = mode3 ? sclk : 1'b1;
    assign bus3.ss_n_i = mode3 ? ss_n : 1'b1;
    assign bus3.mosi_i = mosi;
    assign bus3.din_i  = din3;
    assign bus3.load_i = ld3;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign bus0.rx_ack_i = ack;
    assign bus3.rx_ack_i = 1'b0;
`endif
    assign miso = mode3 ? bus3.miso_o : bus0.miso_o;

    spi_slave_if #(.DW(8), .CPOL(1'b0), .CPHA(1'b0), .DEFAULT_TX(8'hFF)) u_dut0 (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus0.slave)
    );

    spi_slave_if #(.DW(8), .CPOL(1'b1), .CPHA(1'b1), .DEFAULT_TX(8'hFF)) u_dut3 (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus3.slave)
    );

    // Receive monitors: count rx_valid cycles and keep the words they carried
    always @(negedge clk) begin
        if (bus0.rx_valid_o) begin
            rx_cnt0  <= rx_cnt0 + 1;
            rx_last0 <= bus0.dout_o;
        end
        if (bus3.rx_valid_o) begin
            rx_cnt3  <= rx_cnt3 + 1;
            rx_prev3 <= rx_last3;
            rx_last3 <= bus3.dout_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load0(input logic [7:0] d);
        @(negedge clk);
        ld0 = 1'b1; din0 = d;
        @(negedge clk);
        ld0 = 1'b0;
    endtask

    task automatic load3(input logic [7:0] d);
        @(negedge clk);
        ld3 = 1'b1; din3 = d;
        @(negedge clk);
        ld3 = 1'b0;
    endtask

    task automatic select();
        @(negedge clk);
        ss_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic deselect();
        wait_clk(HALF);
        ss_n = 1'b1;
        wait_clk(8);
    endtask

    // SPI master: drives nbits of tx MSB-first and gathers miso at each sample edge
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit cpha,
                        input bit cpol, output logic [7:0] rxw);
        rxw = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = tx[7-i];
                wait_clk(HALF);
                rxw  = {rxw[6:0], miso};
                sclk = ~cpol;
                wait_clk(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = tx[7-i];
                wait_clk(HALF);
                rxw  = {rxw[6:0], miso};
                sclk = cpol;
                wait_clk(HALF);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         base;
        logic [7:0] rx2;

        // 1. reset values, then idle with sclk toggling and ss_n high
        #12;
        check("rst_oe0",    bus0.miso_oe_o,  1'b0);
        check("rst_miso0",  bus0.miso_o,     1'b0);
        check("rst_ready0", bus0.ready_o,    1'b1);
        check("rst_dout0",  bus0.dout_o,     8'h00);
        check("rst_valid0", bus0.rx_valid_o, 1'b0);
        check("rst_busy0",  bus0.busy_o,     1'b0);
        check("rst_ready3", bus3.ready_o,    1'b1);
        check("rst_oe3",    bus3.miso_oe_o,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            wait_clk(HALF);
            sclk = ~sclk;
        end
        sclk = 1'b0;
        wait_clk(8);
        check("idle_oe",    bus0.miso_oe_o, 1'b0);
        check("idle_ready", bus0.ready_o,   1'b1);
        check("idle_dout",  bus0.dout_o,    8'h00);
        check("idle_nrx",   rx_cnt0,        0);

        // 2. mode 0, load A5, master sends 3C
        load0(8'hA5);
        check("m0_ready_full", bus0.ready_o, 1'b0);
        select();
        check("m0_ready_back", bus0.ready_o,   1'b1);
        check("m0_oe",         bus0.miso_oe_o, 1'b1);
        xfer(8'h3C, 8, 1'b0, 1'b0, rx);
        check("m0_miso", rx, 8'hA5);
        deselect();
        check("m0_nrx",  rx_cnt0,       1);
        check("m0_rx",   rx_last0,      8'h3C);
        check("m0_dout", bus0.dout_o,   8'h3C);
        check("m0_oe_off", bus0.miso_oe_o, 1'b0);

        // 3. mode 3 burst of two frames, second word loaded mid-frame
        mode3 = 1'b1;
        sclk  = 1'b1;
        wait_clk(8);
        load3(8'h12);
        check("m3_ready_full", bus3.ready_o, 1'b0);
        select();
        check("m3_ready_back", bus3.ready_o, 1'b1);
        fork
            xfer(8'hF0, 8, 1'b1, 1'b1, rx);
            begin
                wait_clk(20);
                load3(8'h34);
            end
        join
        xfer(8'h0F, 8, 1'b1, 1'b1, rx2);
        deselect();
        check("m3_miso1", rx,       8'h12);
        check("m3_miso2", rx2,      8'h34);
        check("m3_nrx",   rx_cnt3,  2);
        check("m3_rx1",   rx_prev3, 8'hF0);
        check("m3_rx2",   rx_last3, 8'h0F);
        check("m3_ready_end", bus3.ready_o, 1'b1);
        mode3 = 1'b0;
        sclk  = 1'b0;
        wait_clk(8);

        // 4. no word loaded: DEFAULT_TX goes out
        select();
        xfer(8'h55, 8, 1'b0, 1'b0, rx);
        deselect();
        check("dflt_miso", rx,          8'hFF);
        check("dflt_dout", bus0.dout_o, 8'h55);
        check("dflt_nrx",  rx_cnt0,     2);

        // 5. partial frame discarded, following frame received
        base = rx_cnt0;
        select();
        xfer(8'hC3, 5, 1'b0, 1'b0, rx);
        wait_clk(HALF);
        check("part_busy", bus0.busy_o, 1'b1);
        deselect();
        check("part_nrx",  rx_cnt0,        base);
        check("part_dout", bus0.dout_o,    8'h55);
        check("part_oe",   bus0.miso_oe_o, 1'b0);
        check("part_busy_off", bus0.busy_o, 1'b0);
        select();
        xfer(8'h81, 8, 1'b0, 1'b0, rx);
        deselect();
        check("after_dout", bus0.dout_o, 8'h81);
        check("after_nrx",  rx_cnt0,     base + 1);

        // 6. asynchronous reset mid-frame
        select();
        xfer(8'hE7, 3, 1'b0, 1'b0, rx);
        check("mid_oe", bus0.miso_oe_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ar_oe",    bus0.miso_oe_o,  1'b0);
        check("ar_miso",  bus0.miso_o,     1'b0);
        check("ar_ready", bus0.ready_o,    1'b1);
        check("ar_dout",  bus0.dout_o,     8'h00);
        check("ar_valid", bus0.rx_valid_o, 1'b0);
        check("ar_busy",  bus0.busy_o,     1'b0);
        ss_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(8);

`ifdef SPI_SLAVE_OVERRUN_EN
        check("ov_reset", bus0.overrun_o, 1'b0);
        select();
        xfer(8'h11, 8, 1'b0, 1'b0, rx);
        xfer(8'h22, 8, 1'b0, 1'b0, rx);
        deselect();
        check("ov_set", bus0.overrun_o, 1'b1);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        wait_clk(2);
        check("ov_hold", bus0.overrun_o, 1'b1);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        wait_clk(2);
        check("ov_clear", bus0.overrun_o, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
SPI slave (target) endpoint, the far end of the team's SPI master (sclk/mosi/miso, 8-bit frames). It oversamples the external SPI pins in the system clock domain. It shifts MSB-first receive data into dout_o, and shifts transmit data, loaded through a ready/load handshake, out on miso_o. Used as the DUT-side responder for master loopback and as a reusable slave for on-chip SPI peripherals.

Parameters:
DW, 8, frame width in bits (>=2)
CPOL, 0, idle level of sclk_i
CPHA, 0, 0: sample on leading edge / shift on trailing edge; 1: shift on leading edge / sample on trailing edge
DEFAULT_TX, 8'hFF, word shifted out when no transmit word is buffered (DW bits)

Ports:
clk_i  in  1  system clock, must be >= 8x sclk_i frequency
reset_i  in  1  asynchronous, active-low reset
sclk_i  in  1  SPI clock from master (asynchronous)
ss_n_i  in  1  slave select, active low (asynchronous)
mosi_i  in  1  serial data from master
miso_o  out  1  serial data to master
miso_oe_o  out  1  miso output enable; 1 only while selected
din_i  in  DW  transmit word
load_i  in  1  transmit load strobe
ready_o  out  1  transmit holding buffer empty
dout_o  out  DW  last completely received word
rx_valid_o  out  1  one-cycle pulse, dout_o updated
busy_o  out  1  selected and mid-frame

Behaviour:
- Reset values (reset_i=0, async): miso_o=0, miso_oe_o=0, ready_o=1, dout_o=0, rx_valid_o=0, busy_o=0. FSM goes to IDLE, bit counter to 0, tx buffer empty. Synchronizer flops reset to idle levels: sclk=CPOL, ss_n=1.
- Synchronization: 2-flop synchronizers on sclk_i, ss_n_i and mosi_i, plus one history flop on sclk and on ss_n for edge detection.
  - Pin edge to internal action: 3 clk_i cycles.
- Leading edge: the sclk transition away from CPOL. Trailing edge: the transition back to CPOL.
- FSM:
  - IDLE: miso_oe_o=0, miso_o=0. Synchronized ss_n falling edge -> ACTIVE, bit_cnt=0, tx_shift loaded (see the load rule below), miso_oe_o=1.
  - ACTIVE: miso_o = tx_shift[DW-1].
    - Sample edge: rx_shift <= {rx_shift[DW-2:0], mosi_sync}; bit_cnt++.
    - Shift edge: tx_shift <= tx_shift << 1.
    - CPHA=1 only: the first leading edge after select performs no shift, because the MSB is already presented.
    - When the DW-th bit is sampled: dout_o <= assembled word and rx_valid_o=1 for exactly 1 cycle (same cycle as the sample). bit_cnt=0, busy_o drops for that cycle.
    - After the DW-th bit, tx_shift reloads for the next frame (burst continues while ss_n low). CPHA=0: reload at the following trailing edge. CPHA=1: reload immediately.
    - Synchronized ss_n rising edge -> IDLE, next cycle. A partial frame (bit_cnt != 0) is discarded: no rx_valid_o, dout_o unchanged, tx buffer state unchanged.
- busy_o = 1 in ACTIVE when bit_cnt != 0.
- Transmit handshake and load rule:
  - load_i && ready_o: capture din_i, ready_o=0 next cycle.
  - load_i while ready_o=0: ignored; buffer is not overwritten.
  - At each frame load (ss_n fall or burst reload), tx_shift takes the buffer if full, then ready_o returns to 1 next cycle. If the buffer is empty, tx_shift takes DEFAULT_TX.
  - Simultaneous load_i and frame load with an empty buffer: the frame sends DEFAULT_TX, and din_i is captured for the next frame.
- sclk edges while ss_n high are ignored. mosi is not sampled in IDLE.

Optional Feature:
Macro SPI_SLAVE_OVERRUN_EN. When defined, adds output overrun_o (1 bit, reset 0), a sticky flag.
- Set when a frame completes and the consumer has not yet taken the previous word. "Taken" is tracked via added input rx_ack_i: a per-word flag sets on rx_valid_o and clears on rx_ack_i.
- Also set when a frame loads DEFAULT_TX because the buffer was empty and ss_n was low.
- Cleared by rx_ack_i=1 while the per-word flag is clear, or by reset.

Without the macro, neither port exists, and no status logic is generated.

Test Plan:
1. Reset, then idle: -> miso_oe_o=0, ready_o=1, dout_o=0, no rx_valid_o for 100 cycles while sclk toggles with ss_n=1.
2. Mode 0, load 8'hA5, master sends 8'h3C with 8x oversampling: -> miso bits 1,0,1,0,0,1,0,1; dout_o=8'h3C with one rx_valid_o pulse; ready_o=1 after the ss_n fall.
3. Mode 3 (CPOL=1, CPHA=1), 2-byte burst, loads 8'h12 then 8'h34 (second load during the first frame), master sends 8'hF0, 8'h0F: -> miso 8'h12, 8'h34; two rx_valid_o pulses with 8'hF0, 8'h0F.
4. No load, master sends 8'h55: -> miso=8'hFF (DEFAULT_TX); dout_o=8'h55.
5. ss_n deasserted after 5 bits of 8'hC3: -> no rx_valid_o, dout_o keeps its previous value, FSM back in IDLE; the next full frame 8'h81 is received correctly.
6. Assert reset_i low mid-frame after 3 bits: -> all outputs at reset values immediately. With SPI_SLAVE_OVERRUN_EN defined, two frames without rx_ack_i -> overrun_o=1, which stays set until rx_ack_i is pulsed.
